// File: rtl/arb_req_queue_pkg.sv
// Shared defaults for the requester-side arbiter endpoint.
// Every instance that sits on an arbiter input picks these defaults up.
package arb_req_queue_pkg;

   localparam int DEFAULT_DEPTH         = 4;
   localparam int DEFAULT_DATA_WIDTH    = 32;
   localparam int DEFAULT_STARVE_THRESH = 15;
   localparam int DEFAULT_WAIT_WIDTH    = 4;

   // Largest value a wait counter of the given width can hold.
   function automatic int wait_max(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/arb_req_queue_fifo_ram.sv
// Payload storage for the request queue.
// Writes happen on the clock edge; reads are combinational.
module arb_req_queue_fifo_ram #(
   parameter int DEPTH      = 4,
   parameter int LOG_DEPTH  = $clog2(DEPTH),
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  wr_en_i,
   input  logic [LOG_DEPTH-1:0]  wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [LOG_DEPTH-1:0]  rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge CLK) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/arb_req_queue.sv
// Requester-side arbiter endpoint: queues payloads, requests while non-empty,
// pops on ack with a registered grant, and flags a head that waits too long.
module arb_req_queue
   import arb_req_queue_pkg::*;
#(
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int LOG_DEPTH     = $clog2(DEPTH),
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int STARVE_THRESH = DEFAULT_STARVE_THRESH,
   parameter int WAIT_WIDTH    = DEFAULT_WAIT_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  enq_valid,
   input  logic [DATA_WIDTH-1:0] enq_data,
   output logic                  enq_ready,
   input  logic                  flush,
   output logic                  req,
   input  logic                  ack,
   output logic                  grant_valid,
   output logic [DATA_WIDTH-1:0] grant_data,
   output logic [LOG_DEPTH:0]    occupancy,
   output logic                  starved
);

   localparam logic [LOG_DEPTH:0]    PTR_ONE    = {{LOG_DEPTH{1'b0}}, 1'b1};
   localparam logic [WAIT_WIDTH-1:0] WAIT_ONE   = {{(WAIT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WAIT_WIDTH-1:0] WAIT_SAT   = WAIT_WIDTH'(wait_max(WAIT_WIDTH));
   localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(STARVE_THRESH);

   logic [LOG_DEPTH:0]    head_q, head_d;
   logic [LOG_DEPTH:0]    tail_q, tail_d;
   logic [WAIT_WIDTH-1:0] wait_q, wait_d;
   logic                  grant_valid_q, grant_valid_d;
   logic [DATA_WIDTH-1:0] grant_data_q, grant_data_d;

   logic                  full;
   logic                  empty;
   logic                  do_enq;
   logic                  do_pop;
   logic [DATA_WIDTH-1:0] head_data;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full  = (head_q[LOG_DEPTH] != tail_q[LOG_DEPTH]) &&
                  (head_q[LOG_DEPTH-1:0] == tail_q[LOG_DEPTH-1:0]);
   assign empty = (head_q == tail_q);

   assign enq_ready   = ~full;
   assign req         = ~empty;
   assign occupancy   = tail_q - head_q;
   assign starved     = (wait_q >= WAIT_LIMIT);
   assign grant_valid = grant_valid_q;
   assign grant_data  = grant_data_q;

   assign do_enq = enq_valid & ~full & ~flush;
   assign do_pop = ack & ~empty & ~flush;

   arb_req_queue_fifo_ram #(
      .DEPTH      (DEPTH),
      .LOG_DEPTH  (LOG_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo_ram (
      .CLK       (CLK),
      .wr_en_i   (do_enq),
      .wr_addr_i (tail_q[LOG_DEPTH-1:0]),
      .wr_data_i (enq_data),
      .rd_addr_i (head_q[LOG_DEPTH-1:0]),
      .rd_data_o (head_data)
   );

   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      wait_d        = wait_q;
      grant_valid_d = 1'b0;
      grant_data_d  = grant_data_q;

      if (flush) begin
         head_d = '0;
         tail_d = '0;
         wait_d = '0;
      end else begin
         if (do_enq) begin
            tail_d = tail_q + PTR_ONE;
         end
         if (do_pop) begin
            head_d        = head_q + PTR_ONE;
            grant_valid_d = 1'b1;
            grant_data_d  = head_data;
         end
         // Empty here means ack is necessarily absent from a live request.
         if (do_pop || empty) begin
            wait_d = '0;
         end else if (wait_q != WAIT_SAT) begin
            wait_d = wait_q + WAIT_ONE;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q        <= '0;
         tail_q        <= '0;
         wait_q        <= '0;
         grant_valid_q <= 1'b0;
         grant_data_q  <= '0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         wait_q        <= wait_d;
         grant_valid_q <= grant_valid_d;
         grant_data_q  <= grant_data_d;
      end
   end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: a reference FIFO model and scoreboard
// predict every output each cycle; grants are checked against queued payloads.
module tb_arb_req_queue;

   localparam int DEPTH  = 4;
   localparam int DW     = 32;
   localparam int THRESH = 15;
   localparam int WMAX   = 15;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          enq_valid = 1'b0;
   logic [DW-1:0] enq_data = '0;
   logic          enq_ready;
   logic          flush = 1'b0;
   logic          req;
   logic          ack = 1'b0;
   logic          grant_valid;
   logic [DW-1:0] grant_data;
   logic [2:0]    occupancy;
   logic          starved;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DW-1:0] sb_q [$];
   int            cnt_m  = 0;
   int            wait_m = 0;
   logic          exp_gv = 1'b0;

   always #5 CLK = ~CLK;

   arb_req_queue #(
      .DEPTH         (DEPTH),
      .DATA_WIDTH    (DW),
      .STARVE_THRESH (THRESH),
      .WAIT_WIDTH    (4)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .enq_valid   (enq_valid),
      .enq_data    (enq_data),
      .enq_ready   (enq_ready),
      .flush       (flush),
      .req         (req),
      .ack         (ack),
      .grant_valid (grant_valid),
      .grant_data  (grant_data),
      .occupancy   (occupancy),
      .starved     (starved)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cyc(input logic ev, input logic [DW-1:0] d, input logic a,
                      input logic fl, input logic rs);
      bit do_enq, do_pop;
      enq_valid = ev;
      enq_data  = d;
      ack       = a;
      flush     = fl;
      RST       = rs;
      do_enq = ev && (cnt_m < DEPTH);
      do_pop = a && (cnt_m > 0);
      if (rs || fl) begin
         sb_q.delete();
         cnt_m  = 0;
         wait_m = 0;
         exp_gv = 1'b0;
      end else begin
         exp_gv = do_pop;
         if (do_pop || cnt_m == 0) wait_m = 0;
         else if (wait_m < WMAX) wait_m++;
         if (do_enq) sb_q.push_back(d);
         cnt_m = cnt_m + int'(do_enq) - int'(do_pop);
      end
      @(posedge CLK);
      #1;
      chk("grant_valid", {31'd0, grant_valid}, {31'd0, exp_gv});
      if (exp_gv) begin
         if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            chk("grant_data", grant_data, sb_q.pop_front());
         end
      end
      chk("occupancy", {29'd0, occupancy}, cnt_m);
      chk("req", {31'd0, req}, {31'd0, cnt_m != 0});
      chk("enq_ready", {31'd0, enq_ready}, {31'd0, cnt_m < DEPTH});
      chk("starved", {31'd0, starved}, {31'd0, wait_m >= THRESH});
      $display("cyc t=%0t ev=%0b d=%h ack=%0b fl=%0b rst=%0b | gv=%0b gd=%h occ=%0d req=%0b rdy=%0b stv=%0b",
               $time, ev, d, a, fl, rs, grant_valid, grant_data, occupancy, req, enq_ready, starved);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset with ack present: nothing is granted and grant_data is cleared.
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("reset_grant_data", grant_data, 32'h0);
      idle(1);

      // Single entry: request, then one ack yields one grant.
      cyc(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
      idle(1);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(2);

      // Fill to full, attempt an extra enqueue, then drain back to back.
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(2);

      // Occupancy 2, then simultaneous enqueue and ack wrapping the pointers.
      cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'h30 + i, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(1);

      // Ack on empty is ignored; flush beats a concurrent ack.
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h40 + i, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      idle(2);

      // Starvation: hold the request unacked past the threshold, then ack.
      cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      idle(20);
      cyc(1'b1, 32'h56, 1'b1, 1'b0, 1'b0);
      idle(2);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(1);

      // Reset mid-operation with an ack pending.
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h60 + i, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk("midreset_grant_data", grant_data, 32'h0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
